pc_fetch_unit: RTL
==================

# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the unpipelined RISC-V core. Holds the architectural PC and issues one instruction-memory request per instruction. It presents the fetched word to decode, then advances the PC when execute signals completion. The next PC is either PC+4 or the branch/jump target, as selected by the PC_src decision from the branch unit.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- XLEN, 32, address/data width (only 32 supported)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_src  in  1  1 = take target, 0 = PC+4; sampled only on exec_done
- target  in  XLEN  branch/jump target computed by execute
- exec_done  in  1  current instruction has completed execute/writeback
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  fetch data valid
- imem_rsp_data  in  XLEN  fetched instruction word
- inst_valid  out  1  inst/pc/pc_plus4 hold a valid instruction
- inst  out  XLEN  instruction to decode
- pc  out  XLEN  PC of current instruction
- pc_plus4  out  XLEN  pc + 4, for JAL/JALR link and AUIPC
- misalign_trap  out  1  sticky misaligned-target flag (macro only; tied 0 otherwise)

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD (plus TRAP under macro).
- IDLE: one cycle after reset, then REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready, go to WAIT.
- WAIT: on imem_rsp_valid, latch imem_rsp_data into inst, go to HOLD.
- HOLD: inst_valid=1. On exec_done, pc <= pc_src ? aligned(target) : pc+4, inst_valid drops next cycle, go to REQ.
- aligned(target) = {target[31:2],2'b00}.
- pc_plus4 = pc+4, combinational, modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- exec_done is ignored outside HOLD. imem_rsp_valid is ignored outside WAIT.
- Reset outputs: pc=RESET_VECTOR, inst=32'h0000_0013 (NOP), inst_valid=0, imem_req_valid=0, misalign_trap=0, state=IDLE.
- Reset asserted in any state forces these values on the next edge. Any outstanding memory response is dropped.

## Timing
- rst deassert at edge N: IDLE during cycle N, imem_req_valid=1 from cycle N+1.
- A request is accepted in the same cycle that imem_req_valid and imem_req_ready are both high. The earliest response is the following cycle.
- Minimum 3 cycles per instruction (REQ, WAIT, HOLD), with zero-wait memory and exec_done asserted in the first HOLD cycle.
- New pc is visible the cycle after exec_done, in the same cycle that imem_req_valid rises.
- imem_req_addr is stable while imem_req_valid=1 and not yet accepted.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - On exec_done with pc_src=1 and target[1]=1: pc is not updated and misalign_trap is set.
  - FSM enters TRAP and remains there, with no requests and inst_valid=0, until rst.
  - target[0] is still silently cleared.
- Not defined: low two target bits are forced to 0, TRAP state is absent, misalign_trap is tied 0.

## Structure
- Shared package/header fetch_pkg holds: the state encoding, INSTR_BYTES=4, NOP_INSN=32'h0000_0013, and the RESET_VECTOR default.
- One sub-module, next_pc_calc: a combinational next-PC mux (pc+4 / aligned target) plus the misalign detect. The FSM and registers stay in pc_fetch_unit.

## Test plan
- Reset release with ready=1, rsp one cycle after accept -> first imem_req_addr=0, inst latched, inst_valid high 2 cycles after request.
- exec_done with pc_src=0 at pc=0x10 -> next request address 0x14, pc_plus4=0x18.
- exec_done with pc_src=1, target=0x2001 -> next pc 0x2000 (bit0 cleared, both builds).
- imem_req_ready held low 3 cycles -> addr stable, imem_req_valid held, no state advance.
- pc=0xFFFF_FFFC with pc_src=0 -> next pc 0x0. Spurious exec_done in WAIT is ignored.
- With FETCH_MISALIGN_TRAP_EN, target=0x2002 with pc_src=1 -> misalign_trap=1, pc unchanged, no further requests. rst clears all.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the PC/fetch sequencer.
// FETCH_MISALIGN_TRAP_EN adds the TRAP state to the encoding.
package fetch_pkg;

   localparam int unsigned XLEN_DEF         = 32;
   localparam int unsigned INSTR_BYTES      = 4;
   localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_TRAP
   } fetch_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_HOLD
   } fetch_state_e;
`endif

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC select (sequential vs. word-aligned target) and
// detection of a halfword-misaligned taken target.
module next_pc_calc
   import fetch_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] pc,
   input  logic            pc_src,
   input  logic [XLEN-1:0] target,
   output logic [XLEN-1:0] next_pc_c,
   output logic            misalign_c
);

   // Bit 0 of the target is always discarded.
   logic unused_target_lsb;
   assign unused_target_lsb = target[0];

   always_comb begin
      next_pc_c  = pc + XLEN'(INSTR_BYTES);
      misalign_c = pc_src & target[1];
      if (pc_src) begin
         next_pc_c = {target[XLEN-1:2], 2'b00};
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the unpipelined core.
// Define FETCH_MISALIGN_TRAP_EN to trap on targets with bit 1 set.
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned      XLEN         = XLEN_DEF,
   parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEF)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_src,
   input  logic [XLEN-1:0] target,
   input  logic            exec_done,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            misalign_trap
);

   fetch_state_e    state;
   logic [XLEN-1:0] next_pc_c;
   logic            misalign_c;

   next_pc_calc #(
      .XLEN (XLEN)
   ) u_next_pc_calc (
      .pc         (pc),
      .pc_src     (pc_src),
      .target     (target),
      .next_pc_c  (next_pc_c),
      .misalign_c (misalign_c)
   );

   // The request address is the architectural PC, stable while waiting on ready.
   assign imem_req_addr = pc;

`ifndef FETCH_MISALIGN_TRAP_EN
   logic unused_misalign;
   assign unused_misalign = misalign_c;
   assign misalign_trap   = 1'b0;
`endif

   // pc_plus4 is kept as a register updated alongside pc, so it always equals pc + 4.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         pc             <= RESET_VECTOR;
         pc_plus4       <= RESET_VECTOR + XLEN'(INSTR_BYTES);
         inst           <= XLEN'(NOP_INSN);
         inst_valid     <= 1'b0;
         imem_req_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_trap  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               state          <= ST_REQ;
               imem_req_valid <= 1'b1;
            end
            ST_REQ: begin
               if (imem_req_ready) begin
                  state          <= ST_WAIT;
                  imem_req_valid <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  state      <= ST_HOLD;
                  inst       <= imem_rsp_data;
                  inst_valid <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (exec_done) begin
                  inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                  if (misalign_c) begin
                     state         <= ST_TRAP;
                     misalign_trap <= 1'b1;
                  end else
`endif
                  begin
                     state          <= ST_REQ;
                     pc             <= next_pc_c;
                     pc_plus4       <= next_pc_c + XLEN'(INSTR_BYTES);
                     imem_req_valid <= 1'b1;
                  end
               end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_TRAP: begin
               state <= ST_TRAP;
            end
`endif
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
